// File: rtl/rtr_la_route_gen.sv
// Lookahead route generator for a phased-DOR router input port. It captures the
// head flit's route (output port + output resource class) and replays it for body/tail flits.
module rtr_la_route_gen #(
  parameter int num_dimensions       = 2,
  parameter int num_routers_per_dim  = 4,
  parameter int num_nodes_per_router = 1,
  parameter int num_resource_classes = 2,
  parameter int num_ports            = 2*num_dimensions + num_nodes_per_router,
  parameter int dim_addr_width       = $clog2(num_routers_per_dim),
  parameter int router_addr_width    = num_dimensions*dim_addr_width,
  parameter int node_addr_width      = (num_nodes_per_router > 1) ? $clog2(num_nodes_per_router) : 1
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [router_addr_width-1:0]               router_address,
  input  logic                                       flit_valid,
  input  logic                                       flit_head,
  input  logic                                       flit_tail,
  input  logic [router_addr_width+node_addr_width-1:0] flit_dest_addr,
  input  logic [router_addr_width-1:0]               flit_int_addr,
  input  logic [num_resource_classes-1:0]            flit_rc,
  output logic                                       route_valid,
  output logic [num_ports-1:0]                       route_op,
  output logic [num_resource_classes-1:0]            route_orc,
  output logic [1:0]                                 errors
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] IN_PKT = 1'b1;

  localparam logic [node_addr_width:0] node_limit = (node_addr_width+1)'(num_nodes_per_router);

  logic [0:0]                      state_reg;
  logic                            route_valid_reg;
  logic [num_ports-1:0]            route_op_reg;
  logic [num_resource_classes-1:0] route_orc_reg;
  logic [1:0]                      errors_reg;
  logic [num_ports-1:0]            hold_op_reg;
  logic [num_resource_classes-1:0] hold_orc_reg;

  logic                            use_int;
  logic [router_addr_width-1:0]    dest_router;
  logic [node_addr_width-1:0]      dest_node;
  logic [router_addr_width-1:0]    tgt_addr;
  logic [num_resource_classes-1:0] orc_calc;
  logic [num_ports-1:0]            net_op;
  logic [num_ports-1:0]            eject_op;
  logic [num_ports-1:0]            op_calc;
  logic                            found;
  logic                            node_bad;
  logic                            route_illegal;

  logic [dim_addr_width-1:0] own_digit [num_dimensions];
  logic [dim_addr_width-1:0] tgt_digit [num_dimensions];

  assign dest_router = flit_dest_addr[node_addr_width +: router_addr_width];
  assign dest_node   = flit_dest_addr[node_addr_width-1:0];

  // Class 0 heads detour via the intermediate router until they reach it, then advance class.
  assign use_int  = (num_resource_classes == 2) && flit_rc[0] && (router_address != flit_int_addr);
  assign tgt_addr = use_int ? flit_int_addr : dest_router;
  assign orc_calc = use_int ? num_resource_classes'(1)
                            : (num_resource_classes'(1) << (num_resource_classes-1));

  // Dimension 0 is the most-significant address digit.
  for (genvar gi = 0; gi < num_dimensions; gi++) begin : g_digit
    assign own_digit[gi] = router_address[(num_dimensions-1-gi)*dim_addr_width +: dim_addr_width];
    assign tgt_digit[gi] = tgt_addr[(num_dimensions-1-gi)*dim_addr_width +: dim_addr_width];
  end

  always_comb begin
    net_op = '0;
    found  = 1'b0;
    for (int d = 0; d < num_dimensions; d++) begin
      if (!found && (tgt_digit[d] != own_digit[d])) begin
        found  = 1'b1;
        net_op = (tgt_digit[d] < own_digit[d]) ? (num_ports'(1) << (2*d))
                                               : (num_ports'(1) << (2*d+1));
      end
    end
  end

  assign node_bad      = ({1'b0, dest_node} >= node_limit);
  assign eject_op      = (num_ports'(1) << (2*num_dimensions)) << dest_node;
  assign op_calc       = found ? net_op : (node_bad ? '0 : eject_op);
  assign route_illegal = !$onehot(flit_rc) || (!found && node_bad);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      route_valid_reg <= 1'b0;
      route_op_reg    <= '0;
      route_orc_reg   <= '0;
      errors_reg      <= '0;
      hold_op_reg     <= '0;
      hold_orc_reg    <= '0;
    end else begin
      route_valid_reg <= flit_valid;
      errors_reg      <= '0;
      if (flit_valid) begin
        if (flit_head) begin
          // A head inside a packet is still routed; it simply restarts the packet.
          route_op_reg  <= op_calc;
          route_orc_reg <= orc_calc;
          hold_op_reg   <= op_calc;
          hold_orc_reg  <= orc_calc;
          errors_reg    <= {route_illegal, (state_reg == IN_PKT)};
          state_reg     <= flit_tail ? IDLE : IN_PKT;
        end else if (state_reg == IN_PKT) begin
          route_op_reg  <= hold_op_reg;
          route_orc_reg <= hold_orc_reg;
          if (flit_tail) begin
            state_reg <= IDLE;
          end
        end else begin
          route_op_reg  <= '0;
          route_orc_reg <= '0;
          errors_reg    <= 2'b01;
        end
      end
    end
  end

  assign route_valid = route_valid_reg;
  assign route_op    = route_op_reg;
  assign route_orc   = route_orc_reg;
  assign errors      = errors_reg;

endmodule

// File: tb/tb_rtr_la_route_gen.sv
// Directed-vector bench for rtr_la_route_gen: 2D 4x4 mesh, one node per router,
// router (1,2), two resource classes. Bit i of route_op is port i, bit c of route_orc is class c.
module tb_rtr_la_route_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] router_address;
  logic       flit_valid;
  logic       flit_head;
  logic       flit_tail;
  logic [4:0] flit_dest_addr;
  logic [3:0] flit_int_addr;
  logic [1:0] flit_rc;
  logic       route_valid;
  logic [4:0] route_op;
  logic [1:0] route_orc;
  logic [1:0] errors;

  int vectors     = 0;
  int miscompares = 0;
  int step_no     = 0;

  rtr_la_route_gen dut (
    .clk            (clk),
    .reset          (reset),
    .router_address (router_address),
    .flit_valid     (flit_valid),
    .flit_head      (flit_head),
    .flit_tail      (flit_tail),
    .flit_dest_addr (flit_dest_addr),
    .flit_int_addr  (flit_int_addr),
    .flit_rc        (flit_rc),
    .route_valid    (route_valid),
    .route_op       (route_op),
    .route_orc      (route_orc),
    .errors         (errors)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample the registered outputs 1ns after the edge.
  task automatic step(input logic v, input logic h, input logic t,
                      input logic [4:0] dest, input logic [3:0] intr, input logic [1:0] rc);
    flit_valid     = v;
    flit_head      = h;
    flit_tail      = t;
    flit_dest_addr = dest;
    flit_int_addr  = intr;
    flit_rc        = rc;
    @(posedge clk);
    #1;
    step_no++;
    $display("step %0d: v=%b h=%b t=%b dest=%b int=%b rc=%b -> valid=%b op=%b orc=%b err=%b",
             step_no, v, h, t, dest, intr, rc, route_valid, route_op, route_orc, errors);
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [4:0] op,
                            input logic [1:0] orc, input logic [1:0] err);
    chk({tag, ".valid"}, {7'd0, route_valid}, {7'd0, v});
    chk({tag, ".op"},    {3'd0, route_op},    {3'd0, op});
    chk({tag, ".orc"},   {6'd0, route_orc},   {6'd0, orc});
    chk({tag, ".err"},   {6'd0, errors},      {6'd0, err});
  endtask

  initial begin
    reset          = 1'b0;
    router_address = {2'd1, 2'd2};
    flit_valid     = 1'b0;
    flit_head      = 1'b0;
    flit_tail      = 1'b0;
    flit_dest_addr = '0;
    flit_int_addr  = '0;
    flit_rc        = 2'b10;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 1'b0, 5'b00000, 2'b00, 2'b00);
    reset = 1'b1;

    // Body with no head after reset: framing error, zeroed route.
    step(1, 0, 0, {2'd3, 2'd0, 1'b0}, 4'd0, 2'b10);
    expect_out("orphan_body", 1'b1, 5'b00000, 2'b00, 2'b01);
    step(0, 0, 0, 5'd0, 4'd0, 2'b10);
    expect_out("idle0", 1'b0, 5'b00000, 2'b00, 2'b00);

    // Final class to (3,0): dim0 3>1 -> port 1, class 1.
    step(1, 1, 1, {2'd3, 2'd0, 1'b0}, 4'd0, 2'b10);
    expect_out("cls1_dim0_plus", 1'b1, 5'b00010, 2'b10, 2'b00);
    step(0, 0, 0, 5'd0, 4'd0, 2'b10);
    expect_out("idle_hold", 1'b0, 5'b00010, 2'b10, 2'b00);

    // Class 0 at its intermediate router: advance to class 1, dest (1,0) -> port 2.
    step(1, 1, 1, {2'd1, 2'd0, 1'b0}, {2'd1, 2'd2}, 2'b01);
    expect_out("cls_advance", 1'b1, 5'b00100, 2'b10, 2'b00);

    // Class 0 heading to intermediate (0,2): port 0, class 0; then held for body/tail.
    step(1, 1, 0, {2'd3, 2'd3, 1'b0}, {2'd0, 2'd2}, 2'b01);
    expect_out("to_int", 1'b1, 5'b00001, 2'b01, 2'b00);
    step(1, 0, 0, {2'd1, 2'd2, 1'b0}, {2'd3, 2'd3}, 2'b10);
    expect_out("body1_hold", 1'b1, 5'b00001, 2'b01, 2'b00);
    step(1, 0, 0, {2'd2, 2'd1, 1'b0}, {2'd1, 2'd2}, 2'b10);
    expect_out("body2_hold", 1'b1, 5'b00001, 2'b01, 2'b00);
    step(1, 0, 1, {2'd0, 2'd0, 1'b0}, {2'd1, 2'd1}, 2'b10);
    expect_out("tail_hold", 1'b1, 5'b00001, 2'b01, 2'b00);

    // Back-to-back single-flit packets: ejection port 4, then dim1 plus (port 3).
    step(1, 1, 1, {2'd1, 2'd2, 1'b0}, 4'd0, 2'b10);
    expect_out("eject", 1'b1, 5'b10000, 2'b10, 2'b00);
    step(1, 1, 1, {2'd1, 2'd3, 1'b0}, 4'd0, 2'b10);
    expect_out("dim1_plus", 1'b1, 5'b01000, 2'b10, 2'b00);

    // Non-one-hot resource class flags an illegal route input.
    step(1, 1, 1, {2'd2, 2'd2, 1'b0}, {2'd1, 2'd2}, 2'b11);
    chk("rc_not_onehot.err", {6'd0, errors}, 8'b0000_0010);

    // Ejection to a node index beyond the router's nodes: illegal, no port.
    step(1, 1, 1, {2'd1, 2'd2, 1'b1}, 4'd0, 2'b10);
    expect_out("bad_node", 1'b1, 5'b00000, 2'b10, 2'b10);

    // Head inside a packet: framing error but routed and restarted.
    step(1, 1, 0, {2'd0, 2'd2, 1'b0}, 4'd0, 2'b10);
    expect_out("pkt_head", 1'b1, 5'b00001, 2'b10, 2'b00);
    step(1, 1, 0, {2'd1, 2'd1, 1'b0}, 4'd0, 2'b10);
    expect_out("head_in_pkt", 1'b1, 5'b00100, 2'b10, 2'b01);
    step(1, 0, 0, {2'd3, 2'd3, 1'b0}, 4'd0, 2'b01);
    expect_out("restart_body", 1'b1, 5'b00100, 2'b10, 2'b00);

    // Asynchronous reset mid-packet clears outputs before the next edge.
    flit_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    expect_out("async_reset", 1'b0, 5'b00000, 2'b00, 2'b00);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(1, 0, 0, {2'd3, 2'd3, 1'b0}, 4'd0, 2'b10);
    expect_out("body_after_reset", 1'b1, 5'b00000, 2'b00, 2'b01);

    // Orphan tail leaves the state idle, so the next head is clean.
    step(1, 0, 1, {2'd3, 2'd3, 1'b0}, 4'd0, 2'b10);
    expect_out("orphan_tail", 1'b1, 5'b00000, 2'b00, 2'b01);
    step(1, 1, 1, {2'd0, 2'd0, 1'b0}, 4'd0, 2'b10);
    expect_out("head_after_orphan", 1'b1, 5'b00001, 2'b10, 2'b00);
    step(0, 0, 0, 5'd0, 4'd0, 2'b10);
    expect_out("final_idle", 1'b0, 5'b00001, 2'b10, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
